// File: rtl/irq_resp_ctrl_pkg.sv
// Shared types and helpers for the interrupt responder.
package irq_pkg;

    // FSM encoding for the grant sequencer
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        CLEAR  = 2'd2
    } irq_state_e;

    // Ceiling log2, used to validate the ID width at elaboration
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/irq_resp_ctrl_if.sv
// Request/grant bundle between peripherals, the responder and the consumer.
interface irq_resp_ctrl_if #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
);
    logic [N-1:0]    src_req;
    logic [N-1:0]    src_mask;
    logic            irq;
    logic [ID_W-1:0] irq_id;
    logic            irq_ack;
    logic [N-1:0]    pending;
    logic            any_pending;

    // Environment side: sources, mask control and consumer acknowledge
    modport master (
        output src_req, src_mask, irq_ack,
        input  irq, irq_id, pending, any_pending
    );

    // Responder side
    modport slave (
        input  src_req, src_mask, irq_ack,
        output irq, irq_id, pending, any_pending
    );
endinterface

// File: rtl/irq_resp_ctrl_prio_enc.sv
// Combinational lowest-index-first priority encoder.
module prio_enc #(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] idx
);
    // Scan from the top so the lowest set index is the last one written
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                idx   = ID_W'(i);
            end
        end
    end
endmodule

// File: rtl/irq_resp_ctrl.sv
// Sticky pending latch plus fixed-priority req/ack grant sequencer.
module irq_resp_ctrl
    import irq_pkg::*;
#(
    parameter int unsigned N    = 4,
    parameter int unsigned ID_W = 2
) (
    input logic            clk,
    input logic            rst_n,
    irq_resp_ctrl_if.slave bus
);
    // Parameter sanity at elaboration
    if (N < 2 || N > 16) begin : g_bad_n
        $error("irq_resp_ctrl: N out of range");
    end
    if (ID_W != clog2(N)) begin : g_bad_idw
        $error("irq_resp_ctrl: ID_W must equal clog2(N)");
    end

    irq_state_e      state_q, state_d;
    logic [N-1:0]    pending_q, pending_d;
    logic            irq_q, irq_d;
    logic [ID_W-1:0] irq_id_q, irq_id_d;
    logic            any_pending_q, any_pending_d;
    logic [N-1:0]    clr;
    logic [N-1:0]    eligible;
    logic            enc_valid;
    logic [ID_W-1:0] enc_idx;

    assign eligible = pending_q & ~bus.src_mask;

    prio_enc #(.N(N), .ID_W(ID_W)) u_prio_enc (
        .req   (eligible),
        .valid (enc_valid),
        .idx   (enc_idx)
    );

    // Next state: grant sequencing, clear on ack, sticky pending with set-wins
    always_comb begin
        state_d  = state_q;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        clr      = '0;
        unique case (state_q)
            IDLE: begin
                if (enc_valid) begin
                    state_d  = ASSERT;
                    irq_d    = 1'b1;
                    irq_id_d = enc_idx;
                end
            end
            ASSERT: begin
                if (bus.irq_ack) begin
                    state_d = CLEAR;
                    irq_d   = 1'b0;
                    clr     = N'(1) << irq_id_q;
                end
            end
            CLEAR: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
                irq_d   = 1'b0;
            end
        endcase
        pending_d     = (pending_q & ~clr) | bus.src_req;
        any_pending_d = |(pending_d & ~bus.src_mask);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pending_q     <= '0;
            irq_q         <= 1'b0;
            irq_id_q      <= '0;
            any_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            pending_q     <= pending_d;
            irq_q         <= irq_d;
            irq_id_q      <= irq_id_d;
            any_pending_q <= any_pending_d;
        end
    end

    assign bus.irq         = irq_q;
    assign bus.irq_id      = irq_id_q;
    assign bus.pending     = pending_q;
    assign bus.any_pending = any_pending_q;
endmodule

// File: tb/tb_irq_resp_ctrl.sv
// Directed bench for irq_resp_ctrl with hand-computed expectations.
module tb_irq_resp_ctrl;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    irq_resp_ctrl_if #(.N(4), .ID_W(2)) bus ();

    irq_resp_ctrl #(.N(4), .ID_W(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle so outputs are sampled off the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        rst_n        = 1'b0;
        bus.src_req  = '0;
        bus.src_mask = '0;
        bus.irq_ack  = 1'b0;
        tick();
        tick();
        check("rst_irq", 32'(bus.irq), 32'd0);
        check("rst_id", 32'(bus.irq_id), 32'd0);
        check("rst_pend", 32'(bus.pending), 32'd0);
        check("rst_any", 32'(bus.any_pending), 32'd0);
        rst_n = 1'b1;
        tick();
        tick();
        check("idle_irq", 32'(bus.irq), 32'd0);

        // Single source 2
        bus.src_req = 4'b0100;
        tick();
        bus.src_req = '0;
        check("s_pend", 32'(bus.pending), 32'h4);
        check("s_any", 32'(bus.any_pending), 32'd1);
        check("s_irq_early", 32'(bus.irq), 32'd0);
        tick();
        check("s_irq", 32'(bus.irq), 32'd1);
        check("s_id", 32'(bus.irq_id), 32'd2);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("s_ack_irq", 32'(bus.irq), 32'd0);
        check("s_ack_pend", 32'(bus.pending), 32'd0);
        tick();
        tick();
        check("s_quiet", 32'(bus.irq), 32'd0);

        // Priority: sources 1 and 3 together
        bus.src_req = 4'b1010;
        tick();
        bus.src_req = '0;
        tick();
        check("p_irq0", 32'(bus.irq), 32'd1);
        check("p_id0", 32'(bus.irq_id), 32'd1);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("p_clr_irq", 32'(bus.irq), 32'd0);
        check("p_clr_pend", 32'(bus.pending), 32'h8);
        tick();
        check("p_gap_irq", 32'(bus.irq), 32'd0);
        tick();
        check("p_irq1", 32'(bus.irq), 32'd1);
        check("p_id1", 32'(bus.irq_id), 32'd3);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("p_end_pend", 32'(bus.pending), 32'd0);
        tick();
        tick();

        // Masked source stays pending without a grant
        bus.src_mask = 4'b0001;
        bus.src_req  = 4'b0001;
        tick();
        bus.src_req = '0;
        check("m_pend", 32'(bus.pending), 32'h1);
        check("m_any", 32'(bus.any_pending), 32'd0);
        tick();
        tick();
        tick();
        check("m_irq", 32'(bus.irq), 32'd0);
        bus.src_mask = '0;
        tick();
        check("m_un_any", 32'(bus.any_pending), 32'd1);
        check("m_un_irq", 32'(bus.irq), 32'd1);
        check("m_un_id", 32'(bus.irq_id), 32'd0);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        tick();
        tick();

        // Grant is frozen under masking and a higher-priority arrival; re-request on ack edge
        bus.src_req = 4'b0100;
        tick();
        bus.src_req = '0;
        tick();
        check("r_id", 32'(bus.irq_id), 32'd2);
        bus.src_mask = 4'b0100;
        bus.src_req  = 4'b0001;
        tick();
        bus.src_req  = '0;
        bus.src_mask = '0;
        check("r_hold_irq", 32'(bus.irq), 32'd1);
        check("r_hold_id", 32'(bus.irq_id), 32'd2);
        bus.irq_ack = 1'b1;
        bus.src_req = 4'b0100;
        tick();
        bus.irq_ack = 1'b0;
        bus.src_req = '0;
        check("r_pend", 32'(bus.pending), 32'h5);
        check("r_ack_irq", 32'(bus.irq), 32'd0);
        tick();
        tick();
        check("r_g0_id", 32'(bus.irq_id), 32'd0);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        tick();
        tick();
        check("r_g2_irq", 32'(bus.irq), 32'd1);
        check("r_g2_id", 32'(bus.irq_id), 32'd2);
        bus.irq_ack = 1'b1;
        tick();
        bus.irq_ack = 1'b0;
        check("r_end_pend", 32'(bus.pending), 32'd0);
        tick();
        tick();

        // Stuck ack: four grants, one every three cycles
        bus.irq_ack = 1'b1;
        bus.src_req = 4'b1111;
        tick();
        bus.src_req = '0;
        for (int j = 0; j < 4; j++) begin
            tick();
            check("k_irq", 32'(bus.irq), 32'd1);
            check("k_id", 32'(bus.irq_id), 32'(j));
            tick();
            check("k_ack_irq", 32'(bus.irq), 32'd0);
            tick();
            check("k_gap_irq", 32'(bus.irq), 32'd0);
        end
        check("k_pend", 32'(bus.pending), 32'd0);
        bus.irq_ack = 1'b0;
        tick();

        // Reset mid-ASSERT drops the grant asynchronously
        bus.src_req = 4'b0011;
        tick();
        bus.src_req = '0;
        tick();
        check("x_irq_pre", 32'(bus.irq), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("x_irq", 32'(bus.irq), 32'd0);
        check("x_pend", 32'(bus.pending), 32'd0);
        check("x_any", 32'(bus.any_pending), 32'd0);
        check("x_id", 32'(bus.irq_id), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("x_after_irq", 32'(bus.irq), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
